// File: rtl/carfield_vip_pkg.sv
// Shared types and helpers for the carfield VIP preload master: FSM states,
// AXI constants and the AXI4 request/response structs of the driven port.
package carfield_vip_pkg;

  typedef enum logic [2:0] {IDLE, CALC, AW, W, B, DONE} vip_preload_state_e;

  localparam int unsigned Page4k       = 4096;
  localparam int unsigned AxiAddrWidth = 48;
  localparam int unsigned AxiDataWidth = 64;
  localparam int unsigned AxiIdWidth   = 2;
  localparam int unsigned AxiUserWidth = 1;

  localparam logic [1:0] AxiBurstIncr  = 2'b01;
  localparam logic [1:0] AxiRespOkay   = 2'b00;
  localparam logic [1:0] AxiRespSlvErr = 2'b10;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
    logic [3:0]              cache;
    logic [2:0]              prot;
    logic [3:0]              qos;
    logic [3:0]              region;
    logic [5:0]              atop;
    logic [AxiUserWidth-1:0] user;
  } axi_aw_chan_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0]   data;
    logic [AxiDataWidth/8-1:0] strb;
    logic                      last;
    logic [AxiUserWidth-1:0]   user;
  } axi_w_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [1:0]              resp;
    logic [AxiUserWidth-1:0] user;
  } axi_b_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
    logic [3:0]              cache;
    logic [2:0]              prot;
    logic [3:0]              qos;
    logic [3:0]              region;
    logic [AxiUserWidth-1:0] user;
  } axi_ar_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
    logic [AxiUserWidth-1:0] user;
  } axi_r_chan_t;

  typedef struct packed {
    axi_aw_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_mst_req_t;

  typedef struct packed {
    logic         aw_ready;
    logic         ar_ready;
    logic         w_ready;
    logic         b_valid;
    axi_b_chan_t  b;
    logic         r_valid;
    axi_r_chan_t  r;
  } axi_mst_rsp_t;

  // Beats that fit between a page offset and the next 4 KiB boundary.
  function automatic logic [31:0] beats_to_4k(input logic [11:0] addr,
                                              input int unsigned bytes_per_beat);
    return 32'((Page4k - 32'(addr)) / bytes_per_beat);
  endfunction

endpackage

// File: rtl/vip_axi_burst_len_calc.sv
// Burst length selection: min(remaining, max burst, beats left in the 4 KiB page).
module vip_axi_burst_len_calc
  import carfield_vip_pkg::*;
#(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned MaxBeats  = 16
) (
  input  logic [31:0] remaining,
  input  logic [11:0] addr,
  output logic [8:0]  len
);

  localparam int unsigned BytesPerBeat = DataWidth / 8;

  logic [31:0] to_page;
  logic [31:0] lim;

  always_comb begin
    to_page = beats_to_4k(addr, BytesPerBeat);
    lim     = (remaining < 32'(MaxBeats)) ? remaining : 32'(MaxBeats);
    if (to_page < lim) lim = to_page;
    len = 9'(lim);
  end

endmodule

// File: rtl/vip_axi_preload_mst.sv
// AXI4 write master turning (start address, beat count) + word stream into
// INCR bursts that respect the burst size limit and 4 KiB boundaries.
module vip_axi_preload_mst
  import carfield_vip_pkg::*;
#(
  parameter int unsigned AddrWidth  = 48,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned IdWidth    = 2,
  parameter int unsigned AxiId      = 0,
  parameter int unsigned BurstBytes = 1024,
  parameter type axi_req_t = carfield_vip_pkg::axi_mst_req_t,
  parameter type axi_rsp_t = carfield_vip_pkg::axi_mst_rsp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [31:0]          cmd_beats_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  input  logic [DataWidth-1:0] data_i,
  output axi_req_t             axi_req_o,
  input  axi_rsp_t             axi_rsp_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [31:0]          beats_done_o
);

  localparam int unsigned BytesPerBeat  = DataWidth / 8;
  localparam int unsigned SizeLog2      = $clog2(BytesPerBeat);
  localparam int unsigned BeatsPerBurst = BurstBytes / BytesPerBeat;
  localparam int unsigned MaxBeats      = (BeatsPerBurst < 256) ? BeatsPerBurst : 256;

  vip_preload_state_e   state_q;
  logic [AddrWidth-1:0] addr_q;
  logic [31:0]          remaining_q;
  logic [8:0]           len_q;
  logic [8:0]           beat_q;
  logic [8:0]           calc_len;
  logic                 aw_valid_q;
  logic                 b_ready_q;
  logic                 done_q;
  logic                 err_q;
  logic [31:0]          beats_done_q;
  logic                 in_w;
  logic                 w_last;
  logic                 w_fire;
  logic                 misaligned;
  logic                 unused_rsp;

  vip_axi_burst_len_calc #(
    .DataWidth (DataWidth),
    .MaxBeats  (MaxBeats)
  ) i_len_calc (
    .remaining (remaining_q),
    .addr      (addr_q[11:0]),
    .len       (calc_len)
  );

  assign in_w       = (state_q == W);
  assign w_last     = (beat_q == len_q - 9'd1);
  assign w_fire     = in_w & data_valid_i & axi_rsp_i.w_ready;
  assign misaligned = (cmd_addr_i & AddrWidth'(BytesPerBeat - 1)) != '0;
  assign unused_rsp = ^axi_rsp_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      aw_valid_q   <= 1'b0;
      b_ready_q    <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      beats_done_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            addr_q       <= cmd_addr_i;
            remaining_q  <= cmd_beats_i;
            err_q        <= 1'b0;
            beats_done_q <= '0;
            if (cmd_beats_i == '0) begin
              state_q <= DONE;
            end else if (misaligned) begin
              err_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          len_q      <= calc_len;
          aw_valid_q <= 1'b1;
          state_q    <= AW;
        end
        AW: begin
          if (axi_rsp_i.aw_ready) begin
            aw_valid_q <= 1'b0;
            beat_q     <= '0;
            state_q    <= W;
          end
        end
        W: begin
          if (w_fire) begin
            beat_q <= beat_q + 9'd1;
            if (w_last) begin
              b_ready_q <= 1'b1;
              state_q   <= B;
            end
          end
        end
        B: begin
          // An error response is recorded but the command keeps going so the stream drains.
          if (axi_rsp_i.b_valid) begin
            b_ready_q    <= 1'b0;
            if (axi_rsp_i.b.resp != AxiRespOkay) err_q <= 1'b1;
            beats_done_q <= beats_done_q + 32'(len_q);
            addr_q       <= addr_q + (AddrWidth'(len_q) << SizeLog2);
            remaining_q  <= remaining_q - 32'(len_q);
            state_q      <= (remaining_q == 32'(len_q)) ? DONE : CALC;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // AW fields come straight from stable registers; W is a zero-latency pass-through.
  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw.id    = IdWidth'(AxiId);
    axi_req_o.aw.addr  = addr_q;
    axi_req_o.aw.len   = 8'(len_q - 9'd1);
    axi_req_o.aw.size  = 3'(SizeLog2);
    axi_req_o.aw.burst = AxiBurstIncr;
    axi_req_o.aw_valid = aw_valid_q;
    axi_req_o.w.data   = data_i;
    axi_req_o.w.strb   = '1;
    axi_req_o.w.last   = w_last;
    axi_req_o.w_valid  = in_w & data_valid_i;
    axi_req_o.b_ready  = b_ready_q;
    axi_req_o.r_ready  = 1'b1;
  end

  assign data_ready_o = in_w & axi_rsp_i.w_ready;
  assign cmd_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign beats_done_o = beats_done_q;

endmodule

// File: tb/tb_vip_axi_preload_mst.sv
// Directed bench for vip_axi_preload_mst: command table plus reset/degenerate sequences,
// checked against a bench-side AXI slave with memory and AW log.
module tb_vip_axi_preload_mst;
  import carfield_vip_pkg::*;

  logic         clk;
  logic         rst_i;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [47:0]  cmd_addr;
  logic [31:0]  cmd_beats;
  logic         data_valid;
  logic         data_ready;
  logic [63:0]  data;
  axi_mst_req_t axi_req;
  axi_mst_rsp_t axi_rsp;
  logic         busy;
  logic         done;
  logic         err;
  logic [31:0]  beats_done;

  vip_axi_preload_mst #(.BurstBytes(128)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_addr_i   (cmd_addr),
    .cmd_beats_i  (cmd_beats),
    .data_valid_i (data_valid),
    .data_ready_o (data_ready),
    .data_i       (data),
    .axi_req_o    (axi_req),
    .axi_rsp_i    (axi_rsp),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .beats_done_o (beats_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] addr;
    logic [31:0] beats;
    int          consumed;
    logic [31:0] base;
    int          err_idx;
    bit          bp;
    bit          err_acc;
    int          naw;
    logic [47:0] a0; logic [7:0] l0;
    logic [47:0] a1; logic [7:0] l1;
    logic [47:0] a2; logic [7:0] l2;
    bit          exp_err;
    logic [31:0] exp_bd;
  } vec_t;

  int passed = 0;
  int total  = 0;

  // Slave / stream model state
  logic [63:0]  mem [logic [47:0]];
  logic [47:0]  aw_log_a [$];
  logic [7:0]   aw_log_l [$];
  bit           slave_rst, bp;
  int           err_idx, b_cnt, viol, wbeat, wbeat_tot, b_wait;
  int           src_idx, src_total;
  logic [31:0]  src_base;
  logic [47:0]  cur_addr;
  int           cur_len;
  bit           aw_open, b_pend, aw_wait;
  axi_aw_chan_t aw_prev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Decide handshakes on the negedge (inputs are stable until the next posedge), apply after it.
  initial begin
    bit aw_fire, w_fire, b_fire, d_fire, s_clear;
    forever begin
      @(negedge clk);
      aw_fire = 0; w_fire = 0; b_fire = 0; d_fire = 0;
      s_clear = slave_rst || rst_i;
      if (!s_clear) begin
        aw_fire = axi_req.aw_valid && axi_rsp.aw_ready;
        w_fire  = axi_req.w_valid && axi_rsp.w_ready;
        b_fire  = axi_rsp.b_valid && axi_req.b_ready;
        d_fire  = data_valid && data_ready;
        if (aw_wait && axi_req.aw_valid && axi_req.aw != aw_prev) viol++;
        aw_wait = axi_req.aw_valid && !aw_fire;
        aw_prev = axi_req.aw;
        if (w_fire) begin
          if (!aw_open) viol++;
          else begin
            mem[cur_addr + 48'(8 * wbeat)] = axi_req.w.data;
            if (axi_req.w.last != (wbeat == cur_len)) viol++;
            if (axi_req.w.strb != 8'hFF) viol++;
          end
        end
        if (axi_req.ar_valid || !axi_req.r_ready) viol++;
      end
      @(posedge clk); #1;
      if (s_clear) begin
        aw_open = 0; b_pend = 0; aw_wait = 0; wbeat = 0;
        axi_rsp = '0; data_valid = 1'b0;
      end else begin
        if (aw_fire) begin
          aw_log_a.push_back(axi_req.aw.addr);
          aw_log_l.push_back(axi_req.aw.len);
          if (int'(axi_req.aw.addr[11:0]) + (int'(axi_req.aw.len) + 1) * 8 > 4096) viol++;
          if (axi_req.aw.size != 3'd3 || axi_req.aw.burst != AxiBurstIncr || axi_req.aw.id != 2'd0) viol++;
          cur_addr = axi_req.aw.addr; cur_len = int'(axi_req.aw.len);
          aw_open = 1; wbeat = 0;
        end
        if (w_fire && aw_open) begin
          wbeat_tot++;
          if (wbeat == cur_len) begin
            aw_open = 0; b_pend = 1;
            b_wait = bp ? int'($urandom_range(0, 20)) : 0;
          end
          wbeat++;
        end
        if (b_fire) begin
          axi_rsp.b_valid = 1'b0;
          b_cnt++;
        end
        if (b_pend && !axi_rsp.b_valid) begin
          if (b_wait == 0) begin
            axi_rsp.b_valid = 1'b1;
            axi_rsp.b.resp  = (b_cnt == err_idx) ? AxiRespSlvErr : AxiRespOkay;
            b_pend = 0;
          end else b_wait--;
        end
        axi_rsp.aw_ready = bp ? ($urandom_range(0, 3) == 0) : 1'b1;
        axi_rsp.w_ready  = bp ? ($urandom_range(0, 2) == 0) : 1'b1;
        if (d_fire) src_idx++;
        data_valid = (src_idx < src_total) && (bp ? ($urandom_range(0, 2) != 0) : 1'b1);
        data       = {src_base, 32'(src_idx)};
      end
    end
  end

  task automatic prep(input vec_t v);
    mem.delete(); aw_log_a.delete(); aw_log_l.delete();
    viol = 0; b_cnt = 0; wbeat_tot = 0;
    err_idx = v.err_idx; bp = v.bp;
    src_idx = 0; src_total = v.consumed; src_base = v.base;
  endtask

  task automatic run_cmd(input int id, input vec_t v);
    int cyc, dones, bad;
    logic [47:0] ea [3];
    logic [7:0]  el [3];
    logic [47:0] key;
    ea = '{v.a0, v.a1, v.a2};
    el = '{v.l0, v.l1, v.l2};
    @(posedge clk); #2;
    prep(v);
    cmd_valid = 1'b1; cmd_addr = v.addr; cmd_beats = v.beats;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_err_at_accept", id), 64'(err), 64'(v.err_acc));
    chk($sformatf("v%0d_bd_at_accept", id), 64'(beats_done), 64'd0);
    dones = done ? 1 : 0;
    cyc = 0;
    while (dones == 0 && cyc < 20000) begin
      @(negedge clk);
      if (done) dones++;
      cyc++;
    end
    chk($sformatf("v%0d_done_seen", id), 64'(dones > 0), 64'd1);
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk($sformatf("v%0d_done_pulses", id), 64'(dones), 64'd1);
    chk($sformatf("v%0d_naw", id), 64'(aw_log_a.size()), 64'(v.naw));
    for (int j = 0; j < 3 && j < v.naw; j++) begin
      chk($sformatf("v%0d_aw%0d_addr", id, j),
          64'((j < aw_log_a.size()) ? aw_log_a[j] : 48'hFFFF_FFFF_FFFF), 64'(ea[j]));
      chk($sformatf("v%0d_aw%0d_len", id, j),
          64'((j < aw_log_l.size()) ? aw_log_l[j] : 8'hFF), 64'(el[j]));
    end
    chk($sformatf("v%0d_err", id), 64'(err), 64'(v.exp_err));
    chk($sformatf("v%0d_beats_done", id), 64'(beats_done), 64'(v.exp_bd));
    chk($sformatf("v%0d_consumed", id), 64'(src_idx), 64'(v.consumed));
    chk($sformatf("v%0d_mem_words", id), 64'(mem.num()), 64'(v.consumed));
    bad = 0;
    for (int i = 0; i < v.consumed; i++) begin
      key = v.addr + 48'(8 * i);
      if (!mem.exists(key)) bad++;
      else if (mem[key] != {v.base, 32'(i)}) bad++;
    end
    chk($sformatf("v%0d_mem_data_bad", id), 64'(bad), 64'd0);
    chk($sformatf("v%0d_protocol_viol", id), 64'(viol), 64'd0);
    chk($sformatf("v%0d_busy_end", id), 64'(busy), 64'd0);
  endtask

  initial begin
    vec_t tv [7];
    int cyc;
    tv[0] = '{48'h8000_0000, 32'd40, 40, 32'h0A00, -1, 1'b0, 1'b0, 3,
              48'h8000_0000, 8'd15, 48'h8000_0080, 8'd15, 48'h8000_0100, 8'd7, 1'b0, 32'd40};
    tv[1] = '{48'h8000_0FC0, 32'd16, 16, 32'h0B00, -1, 1'b0, 1'b0, 2,
              48'h8000_0FC0, 8'd7, 48'h8000_1000, 8'd7, 48'h0, 8'd0, 1'b0, 32'd16};
    tv[2] = '{48'h8000_0000, 32'd40, 40, 32'h0C00, 1, 1'b0, 1'b0, 3,
              48'h8000_0000, 8'd15, 48'h8000_0080, 8'd15, 48'h8000_0100, 8'd7, 1'b1, 32'd40};
    tv[3] = '{48'h8001_0040, 32'd1000, 1000, 32'h0D00, -1, 1'b1, 1'b0, 63,
              48'h8001_0040, 8'd15, 48'h8001_00C0, 8'd15, 48'h8001_0140, 8'd15, 1'b0, 32'd1000};
    tv[4] = '{48'h8000_0004, 32'd8, 0, 32'h0E00, -1, 1'b0, 1'b1, 0,
              48'h0, 8'd0, 48'h0, 8'd0, 48'h0, 8'd0, 1'b1, 32'd0};
    tv[5] = '{48'h8000_2000, 32'd0, 0, 32'h0F00, -1, 1'b0, 1'b0, 0,
              48'h0, 8'd0, 48'h0, 8'd0, 48'h0, 8'd0, 1'b0, 32'd0};
    tv[6] = '{48'h8000_3000, 32'd8, 8, 32'h1100, -1, 1'b0, 1'b0, 1,
              48'h8000_3000, 8'd7, 48'h0, 8'd0, 48'h0, 8'd0, 1'b0, 32'd8};

    rst_i = 1'b1; slave_rst = 1'b1; bp = 1'b0; err_idx = -1;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
    data_valid = 1'b0; data = '0; axi_rsp = '0;
    src_idx = 0; src_total = 0; src_base = '0; viol = 0; b_cnt = 0; wbeat = 0; wbeat_tot = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_outputs", 64'({data_ready, busy, done, err}), 64'd0);
    chk("rst_beats_done", 64'(beats_done), 64'd0);
    chk("rst_axi_ctrl", 64'({axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready,
                             axi_req.ar_valid, axi_req.r_ready}), 64'b00001);
    @(posedge clk); #2;
    rst_i = 1'b0; slave_rst = 1'b0;

    for (int i = 0; i < 6; i++) run_cmd(i, tv[i]);

    // Zero-beat command: done two cycles after acceptance, never any AW.
    @(posedge clk); #2;
    prep(tv[5]);
    cmd_valid = 1'b1; cmd_addr = 48'h8000_2000; cmd_beats = 32'd0;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("zero_done_c1", 64'({done, busy, axi_req.aw_valid}), 64'b010);
    @(negedge clk);
    chk("zero_done_c2", 64'({done, busy, axi_req.aw_valid}), 64'b100);
    @(negedge clk);
    chk("zero_done_c3", 64'({done, busy, axi_req.aw_valid}), 64'b000);

    // Reset in the middle of a W burst.
    @(posedge clk); #2;
    prep(tv[0]);
    src_base = 32'h1000;
    cmd_valid = 1'b1; cmd_addr = 48'h8000_0000; cmd_beats = 32'd40;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    cyc = 0;
    while (wbeat_tot < 5 && cyc < 200) begin
      @(posedge clk); #2;
      cyc++;
    end
    chk("rstw_reach_beat5", 64'(wbeat_tot), 64'd5);
    chk("rstw_in_w", 64'(axi_req.w_valid), 64'd1);
    rst_i = 1'b1; slave_rst = 1'b1; src_total = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rstw_axi_valids", 64'({axi_req.w_valid, axi_req.aw_valid, axi_req.b_ready}), 64'd0);
    chk("rstw_busy", 64'(busy), 64'd0);
    chk("rstw_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rstw_status", 64'({done, err, data_ready}), 64'd0);
    @(posedge clk); #2;
    rst_i = 1'b0; slave_rst = 1'b0;
    run_cmd(6, tv[6]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
